// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the main-memory arbiter
package mem_pkg;
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  localparam int MEM_LATENCY = 4;
  localparam int BLOCK_WORDS = 8;
endpackage

// File: rtl/outstanding_ctr.sv
// outstanding_ctr: saturating up/down count of reads in flight
module outstanding_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic at_max,
  output logic is_zero,
  output logic underflow_err
);
  localparam int CW = $clog2(MAX + 1);
  logic [CW-1:0] count;
  logic up, dn;
  assign at_max = count == CW'(MAX);
  assign is_zero = count == '0;
  assign underflow_err = dec & is_zero;
  assign up = inc & ~at_max;
  assign dn = dec & ~is_zero;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else count <= (up & ~dn) ? count + CW'(1) : (dn & ~up) ? count - CW'(1) : count;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin owner of the shared memory port for I- and D-cache engines
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_accept,
  output logic              i_data_valid,
  input  logic              d_req,
  input  logic              d_wrt,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_wdata,
  output logic              d_accept,
  output logic              d_data_valid,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic              mem_data_valid,
  output logic              protocol_err
);
  arb_state_t state, state_nxt;
  owner_t last, last_nxt;
  logic at_max, is_zero, uerr;
  outstanding_ctr #(.MAX(MAX_OUTSTANDING)) u_ctr (
    .clk(clk),
    .rst(rst),
    .inc(mem_enable & ~mem_wr),
    .dec(mem_data_valid),
    .at_max(at_max),
    .is_zero(is_zero),
    .underflow_err(uerr)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      last <= OWN_I;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nxt;
      last <= last_nxt;
      protocol_err <= protocol_err | uerr;
    end
  // ownership only ends once every read issued under it has returned
  always_comb begin
    state_nxt = state;
    last_nxt = last;
    case (state)
      IDLE:  state_nxt = (d_req & (~i_req | last == OWN_I)) ? GNT_D : i_req ? GNT_I : IDLE;
      GNT_I: if (~i_req & is_zero) begin
        state_nxt = IDLE;
        last_nxt = OWN_I;
      end
      GNT_D: if (~d_req & is_zero) begin
        state_nxt = IDLE;
        last_nxt = OWN_D;
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign i_accept = (state == GNT_I) & i_req & ~at_max;
  assign d_accept = (state == GNT_D) & d_req & (d_wrt | ~at_max);
  assign mem_enable = i_accept | d_accept;
  assign mem_wr = d_wrt & (state == GNT_D);
  assign mem_addr = (state == GNT_D) ? d_addr : (state == GNT_I) ? i_addr : '0;
  assign mem_wdata = (state == GNT_D) ? d_wdata : '0;
  assign i_data_valid = mem_data_valid & (state == GNT_I);
  assign d_data_valid = mem_data_valid & (state == GNT_D);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed traffic checked against a transaction-level model
module tb_mem_arbiter;
  import mem_pkg::*;
  localparam int MAXO = 4;
  logic clk = 0, rst = 1;
  logic i_req = 0, d_req = 0, d_wrt = 0, mem_data_valid = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic i_accept, i_data_valid, d_accept, d_data_valid, mem_enable, mem_wr, protocol_err;
  logic [15:0] mem_addr, mem_wdata;
  int tests = 0, fails = 0, cyc = 0;
  int own = 0, last = 1, cnt = 0;
  bit perr = 0, auto_start = 0, spur = 0;
  int ret_q[$];
  bit i_act = 0, d_act = 0, d_w = 0;
  int i_left = 0, d_left = 0, nd_dv = 0, ni_dv = 0;
  logic [15:0] i_a = 0, d_a = 0, d_wd = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.MAX_OUTSTANDING(MAXO), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_accept(i_accept), .i_data_valid(i_data_valid),
    .d_req(d_req), .d_wrt(d_wrt), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_accept(d_accept), .d_data_valid(d_data_valid),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_valid(mem_data_valid), .protocol_err(protocol_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_i_accept"}, i_accept, 0);
    check({tag, "_d_accept"}, d_accept, 0);
    check({tag, "_mem_enable"}, mem_enable, 0);
    check({tag, "_mem_wr"}, mem_wr, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_protocol_err"}, protocol_err, 0);
  endtask
  task automatic start_i(input logic [15:0] a);
    i_act = 1; i_left = BLOCK_WORDS; i_a = a;
  endtask
  task automatic start_d(input logic [15:0] a, input int n, input bit w, input logic [15:0] wd);
    d_act = 1; d_left = n; d_a = a; d_w = w; d_wd = wd;
  endtask
  task automatic step();
    bit ia, da, dv, iss, dec;
    @(posedge clk);
    #1;
    cyc++;
    if (auto_start) begin
      if (!i_act && $urandom_range(0, 7) == 0) start_i(16'($urandom) & 16'hfff8);
      if (!d_act && $urandom_range(0, 5) == 0)
        start_d(16'($urandom), $urandom_range(1, BLOCK_WORDS), 1'($urandom_range(0, 2) == 0), 16'($urandom));
    end
    i_req = i_act;
    i_addr = i_act ? i_a : 16'($urandom);
    d_req = d_act;
    d_wrt = d_act & d_w;
    d_addr = d_act ? d_a : 16'($urandom);
    d_wdata = d_act ? d_wd : 16'($urandom);
    dv = spur;
    if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
      dv = 1;
      void'(ret_q.pop_front());
    end
    spur = 0;
    mem_data_valid = dv;
    #3;
    ia = own == 1 && i_req && cnt < MAXO;
    da = own == 2 && d_req && (d_wrt || cnt < MAXO);
    check("i_accept", i_accept, ia);
    check("d_accept", d_accept, da);
    check("mem_enable", mem_enable, ia | da);
    check("mem_wr", mem_wr, own == 2 && d_wrt);
    check("mem_addr", mem_addr, own == 1 ? i_addr : own == 2 ? d_addr : 16'h0);
    check("mem_wdata", mem_wdata, own == 2 ? d_wdata : 16'h0);
    check("i_data_valid", i_data_valid, dv && own == 1);
    check("d_data_valid", d_data_valid, dv && own == 2);
    check("protocol_err", protocol_err, perr);
    nd_dv += int'(d_data_valid);
    ni_dv += int'(i_data_valid);
    iss = ia || (da && !d_wrt);
    if (iss) ret_q.push_back(cyc + MEM_LATENCY);
    dec = dv && cnt > 0;
    if (dv && cnt == 0) perr = 1;
    if (own == 0) own = (i_req && d_req) ? (last == 1 ? 2 : 1) : d_req ? 2 : i_req ? 1 : 0;
    else if (own == 1 && !i_req && cnt == 0) begin own = 0; last = 1; end
    else if (own == 2 && !d_req && cnt == 0) begin own = 0; last = 2; end
    cnt = cnt + int'(iss) - int'(dec);
    if (ia) begin i_a++; if (--i_left == 0) i_act = 0; end
    if (da) begin d_a++; if (--d_left == 0) d_act = 0; end
  endtask
  task automatic drain(input string tag, input int lim);
    int n = 0;
    while ((i_act || d_act || own != 0 || ret_q.size() > 0) && n < lim) begin
      step();
      n++;
    end
    check({tag, "_drained"}, n < lim, 1);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask
  initial begin
    #1;
    check_zero("reset");
    check("reset_i_dv", i_data_valid, 0);
    check("reset_d_dv", d_data_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // simultaneous requests right after reset: D wins, then I, then D again
    start_i(16'h0400);
    start_d(16'h0800, 2, 0, 0);
    drain("tie1", 100);
    start_i(16'h0410);
    start_d(16'h0810, 2, 0, 0);
    drain("tie2", 100);
    idle(2);
    nd_dv = 0;
    ni_dv = 0;
    start_d(16'h1230, BLOCK_WORDS, 0, 0);
    drain("dfill", 100);
    check("dfill_d_pulses", nd_dv, BLOCK_WORDS);
    check("dfill_i_pulses", ni_dv, 0);
    idle(2);
    start_d(16'h00f2, 1, 1, 16'hbeef);
    drain("dwrite", 20);
    idle(1);
    start_d(16'h2000, BLOCK_WORDS, 0, 0);
    idle(3);
    start_i(16'h3000);
    drain("i_mid_d", 150);
    idle(2);
    spur = 1;
    idle(4);
    check("spurious_sticky", perr, 1);
    start_d(16'h4000, BLOCK_WORDS, 0, 0);
    for (int k = 0; k < 20 && cnt != 3; k++) step();
    check("three_in_flight", cnt, 3);
    #1 rst = 1;
    #1;
    check_zero("async_rst");
    own = 0; last = 1; cnt = 0; perr = 0;
    ret_q.delete();
    i_act = 0; d_act = 0;
    i_req = 0; d_req = 0; d_wrt = 0; mem_data_valid = 0;
    repeat (2) begin @(posedge clk); cyc++; end
    #1 rst = 0;
    start_d(16'h5000, 3, 0, 0);
    drain("post_rst", 60);
    auto_start = 1;
    idle(1500);
    auto_start = 0;
    drain("random", 300);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
